grid_cursor_ctrl: RTL and testbench



---
 rtl/grid_cursor_pkg.sv | 23 ++
 rtl/grid_cursor_ctrl_cell_to_pixel.sv | 24 ++
 rtl/grid_cursor_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_grid_cursor_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/grid_cursor_pkg.sv
// Shared types, default board geometry and the wrap helper for the grid cursor controller.
package grid_cursor_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam int DEF_GRID_N       = 3;
    localparam int DEF_CELL_W       = 160;
    localparam int DEF_CELL_H       = 160;
    localparam int DEF_ORIGIN_X     = 80;
    localparam int DEF_ORIGIN_Y     = 0;
    localparam int DEF_SPR_SIZE     = 64;
    localparam int DEF_REPEAT_DELAY = 20;
    localparam int DEF_REPEAT_RATE  = 6;
    localparam int DEF_BLINK_FRAMES = 16;

    // One step along an axis of n cells, wrapping at both ends.
    function automatic int wrap_step(input int v, input logic inc, input int n);
        if (inc) return (v == n - 1) ? 0 : v + 1;
        else     return (v == 0) ? n - 1 : v - 1;
    endfunction

endpackage

// File: rtl/grid_cursor_ctrl_cell_to_pixel.sv
// Combinational cell -> sprite top-left pixel mapping; the sprite is centred in its cell.
module cell_to_pixel
    import grid_cursor_pkg::*;
#(
    parameter int GRID_N   = DEF_GRID_N,
    parameter int CELL_W   = DEF_CELL_W,
    parameter int CELL_H   = DEF_CELL_H,
    parameter int ORIGIN_X = DEF_ORIGIN_X,
    parameter int ORIGIN_Y = DEF_ORIGIN_Y,
    parameter int SPR_SIZE = DEF_SPR_SIZE
) (
    input  logic [$clog2(GRID_N)-1:0] i_row,
    input  logic [$clog2(GRID_N)-1:0] i_col,
    output logic [9:0]                o_posx,
    output logic [9:0]                o_posy
);

    localparam logic [9:0] OFF_X = 10'(ORIGIN_X + (CELL_W - SPR_SIZE) / 2);
    localparam logic [9:0] OFF_Y = 10'(ORIGIN_Y + (CELL_H - SPR_SIZE) / 2);

    assign o_posx = OFF_X + 10'(i_col) * 10'(CELL_W);
    assign o_posy = OFF_Y + 10'(i_row) * 10'(CELL_H);

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Frame-synchronous grid cursor: buttons -> step/auto-repeat moves, sprite position, place strobe.
// Optional cursor blinking is built when GRID_CURSOR_BLINK_EN is defined.
module grid_cursor_ctrl
    import grid_cursor_pkg::*;
#(
    parameter int GRID_N       = DEF_GRID_N,
    parameter int CELL_W       = DEF_CELL_W,
    parameter int CELL_H       = DEF_CELL_H,
    parameter int ORIGIN_X     = DEF_ORIGIN_X,
    parameter int ORIGIN_Y     = DEF_ORIGIN_Y,
    parameter int SPR_SIZE     = DEF_SPR_SIZE,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_sel,
    input  logic                      lock,
    output logic [9:0]                posx,
    output logic [9:0]                posy,
    output logic                      enable,
    output logic [$clog2(GRID_N)-1:0] cell_row,
    output logic [$clog2(GRID_N)-1:0] cell_col,
    output logic                      place
);

    localparam int RC_W    = $clog2(GRID_N);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            r_state, w_state_nxt;
    dir_t              r_dir, w_dir_nxt, w_dir;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [RC_W-1:0]   r_row, r_col, w_row_nxt, w_col_nxt;
    logic [RC_W-1:0]   r_place_row, r_place_col;
    logic [9:0]        r_posx, r_posy, w_posx, w_posy;
    logic              r_sel_prev, r_place;
    logic              w_dir_vld, w_move, w_sel_rise, w_same;

    assign w_dir_vld = btn_up | btn_down | btn_left | btn_right;
    assign w_dir     = btn_up ? DIR_UP : btn_down ? DIR_DOWN : btn_left ? DIR_LEFT : DIR_RIGHT;
    assign w_same    = w_dir_vld && (w_dir == r_dir);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_move      = 1'b0;
        if (frame_tick) begin
            if (lock) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_dir_vld) begin
                        w_move      = 1'b1;
                        w_dir_nxt   = w_dir;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DELAY;
                    end
                    S_DELAY: if (!w_same) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        w_move      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    S_REPEAT: if (!w_same) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == CNT_W'(REPEAT_RATE - 1)) begin
                        w_move    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // A move only fires when the current winner is the direction being applied.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (w_move) begin
            case (w_dir)
                DIR_UP:    w_row_nxt = RC_W'(wrap_step(int'(r_row), 1'b0, GRID_N));
                DIR_DOWN:  w_row_nxt = RC_W'(wrap_step(int'(r_row), 1'b1, GRID_N));
                DIR_LEFT:  w_col_nxt = RC_W'(wrap_step(int'(r_col), 1'b0, GRID_N));
                DIR_RIGHT: w_col_nxt = RC_W'(wrap_step(int'(r_col), 1'b1, GRID_N));
                default: ;
            endcase
        end
    end

    assign w_sel_rise = frame_tick & ~lock & btn_sel & ~r_sel_prev;

    cell_to_pixel #(
        .GRID_N(GRID_N), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .SPR_SIZE(SPR_SIZE)
    ) u_c2p (
        .i_row  (w_row_nxt),
        .i_col  (w_col_nxt),
        .o_posx (w_posx),
        .o_posy (w_posy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir       <= DIR_UP;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_posx      <= 10'(ORIGIN_X + (CELL_W - SPR_SIZE) / 2);
            r_posy      <= 10'(ORIGIN_Y + (CELL_H - SPR_SIZE) / 2);
            r_sel_prev  <= 1'b0;
            r_place     <= 1'b0;
            r_place_row <= '0;
            r_place_col <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_posx  <= w_posx;
            r_posy  <= w_posy;
            r_place <= w_sel_rise;
            if (frame_tick) r_sel_prev <= btn_sel;
            if (w_sel_rise) begin
                r_place_row <= r_row;
                r_place_col <= r_col;
            end
        end
    end

    assign posx  = r_posx;
    assign posy  = r_posy;
    assign place = r_place;
    // During the strobe the cell seen is the one selected, even if a move landed on the same tick.
    assign cell_row = r_place ? r_place_row : r_row;
    assign cell_col = r_place ? r_place_col : r_col;

`ifdef GRID_CURSOR_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_enable    <= 1'b1;
        end else if (frame_tick) begin
            if (lock || w_move || w_sel_rise) begin
                r_blink_cnt <= '0;
                r_enable    <= 1'b1;
            end else if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_enable    <= ~r_enable;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign enable = r_enable;
`else
    assign enable = 1'b1;
`endif

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Bench for grid_cursor_ctrl: directed scenarios plus randomized button sequences vs a tick-level model.
module tb_grid_cursor_ctrl;
    import grid_cursor_pkg::*;

    localparam int N  = 3;
    localparam int D  = 20;
    localparam int R  = 6;
    localparam int BF = 16;

    logic clk = 1'b0, rst = 1'b0, frame_tick = 1'b0;
    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_sel = 0, lock = 0;
    logic [9:0] posx, posy;
    logic       enable, place;
    logic [1:0] cell_row, cell_col;

    grid_cursor_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_sel(btn_sel), .lock(lock),
        .posx(posx), .posy(posy), .enable(enable),
        .cell_row(cell_row), .cell_col(cell_col), .place(place)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int place_seen = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // reference model: counts consecutive ticks a direction has been held
    int m_row, m_col, m_hold_dir, m_hold, m_prev, m_en, m_bc;
    int e_place, e_prow, e_pcol;

    function automatic int winner(input logic u, d, l, r);
        return u ? 0 : d ? 1 : l ? 2 : r ? 3 : -1;
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0; m_hold_dir = -1; m_hold = 0; m_prev = 0; m_en = 1; m_bc = 0;
        exp_q.delete();
    endtask

    task automatic model_tick(input logic u, d, l, r, s, lk);
        int w, mv;
        w = winner(u, d, l, r);
        mv = 0;
        e_place = 0;
        if (lk) begin
            m_hold_dir = -1; m_hold = 0;
        end else begin
            e_place = (s && !m_prev) ? 1 : 0;
            if (m_hold_dir < 0) begin
                if (w >= 0) begin mv = 1; m_hold_dir = w; m_hold = 1; end
            end else if (w != m_hold_dir) begin
                m_hold_dir = -1; m_hold = 0;
            end else begin
                m_hold++;
                if (m_hold == 1 + D) mv = 1;
                else if (m_hold > 1 + D && (m_hold - 1 - D) % R == 0) mv = 1;
            end
        end
        e_prow = m_row; e_pcol = m_col;
        if (e_place) exp_q.push_back({2'(m_row), 2'(m_col)});
        if (mv) begin
            case (w)
                0: m_row = (m_row + N - 1) % N;
                1: m_row = (m_row + 1) % N;
                2: m_col = (m_col + N - 1) % N;
                default: m_col = (m_col + 1) % N;
            endcase
        end
        m_prev = s;
`ifdef GRID_CURSOR_BLINK_EN
        if (lk || mv || e_place) begin m_en = 1; m_bc = 0; end
        else if (m_bc == BF - 1) begin m_en = 1 - m_en; m_bc = 0; end
        else m_bc++;
`endif
    endtask

    task automatic observe_place();
        logic [3:0] e;
        if (place) begin
            place_seen++;
            if (exp_q.size() == 0) check("unexpected_place", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("place_cell", int'({cell_row, cell_col}), int'(e));
            end
        end
    endtask

    // driver: one frame tick with the given levels, then a short gap
    task automatic do_tick(input logic u, d, l, r, s, lk);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s; lock = lk;
        frame_tick = 1'b1;
        model_tick(u, d, l, r, s, lk);
        @(negedge clk);
        frame_tick = 1'b0;
        check("posx", int'(posx), 80 + m_col * 160 + 48);
        check("posy", int'(posy), m_row * 160 + 48);
        check("enable", int'(enable), m_en);
        check("place", int'(place), e_place);
        check("cell_row", int'(cell_row), e_place ? e_prow : m_row);
        check("cell_col", int'(cell_col), e_place ? e_pcol : m_col);
        check("fsm_idle", int'(dut.r_state == S_IDLE), int'(m_hold_dir < 0));
        observe_place();
        repeat (1 + $urandom_range(0, 2)) begin
            @(negedge clk);
            check("place_gap", int'(place), 0);
            check("row_gap", int'(cell_row), m_row);
            check("col_gap", int'(cell_col), m_col);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_posx", int'(posx), 128);
        check("rst_posy", int'(posy), 48);
        check("rst_enable", int'(enable), 1);
        check("rst_place", int'(place), 0);
        check("rst_row", int'(cell_row), 0);
        check("rst_col", int'(cell_col), 0);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0; lock = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int mv_ticks[$];
    int exp_mv[5] = '{1, 21, 27, 33, 39};
    int exp_rows[5] = '{1, 2, 0, 1, 2};
    int row_seq[$];

    initial begin
        int prev_row, p0, hold_len;
        logic u, d, l, r, lk;
        model_reset();
        do_reset();

        // single step right then release
        do_tick(0, 0, 0, 1, 0, 0);
        check("step_col", int'(cell_col), 1);
        check("step_posx", int'(posx), 288);
        repeat (5) do_tick(0, 0, 0, 0, 0, 0);
        check("step_hold_col", int'(cell_col), 1);

        // auto-repeat down for 40 ticks
        prev_row = int'(cell_row);
        for (int i = 1; i <= 40; i++) begin
            do_tick(0, 1, 0, 0, 0, 0);
            if (int'(cell_row) != prev_row) begin
                mv_ticks.push_back(i);
                row_seq.push_back(int'(cell_row));
            end
            prev_row = int'(cell_row);
        end
        check("rep_count", mv_ticks.size(), 5);
        for (int i = 0; i < 5 && i < mv_ticks.size(); i++) begin
            check("rep_tick", mv_ticks[i], exp_mv[i]);
            check("rep_row", row_seq[i], exp_rows[i]);
        end
        do_tick(0, 0, 0, 0, 0, 0);

        // reset mid-operation, then up+left wraps the row, col untouched
        do_tick(0, 0, 1, 0, 0, 0);
        do_reset();
        do_tick(1, 0, 1, 0, 0, 0);
        check("wrap_row", int'(cell_row), 2);
        check("wrap_posy", int'(posy), 368);
        check("wrap_col", int'(cell_col), 0);
        do_tick(0, 0, 0, 0, 0, 0);

        // walk to (1,2) and hold select
        do_tick(1, 0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0, 0);
        do_tick(0, 0, 1, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0, 0);
        p0 = place_seen;
        repeat (10) do_tick(0, 0, 0, 0, 1, 0);
        check("sel_pulses", place_seen - p0, 1);
        do_tick(0, 0, 0, 0, 0, 0);

        // locked press: nothing happens, and unlock with select held gives no strobe
        p0 = place_seen;
        repeat (10) do_tick(0, 0, 0, 1, 1, 1);
        check("lock_col", int'(cell_col), 2);
        check("lock_pulses", place_seen - p0, 0);
        repeat (3) do_tick(0, 0, 0, 0, 1, 0);
        check("unlock_pulses", place_seen - p0, 0);

        // select and move on the same tick
        do_tick(0, 0, 0, 0, 0, 0);
        do_tick(0, 1, 0, 0, 1, 0);
        do_tick(0, 0, 0, 0, 0, 0);

        // randomized held-button segments
        for (int seg = 0; seg < 40; seg++) begin
            u = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            lk = ($urandom_range(0, 7) == 0);
            hold_len = $urandom_range(1, 40);
            for (int t = 0; t < hold_len; t++)
                do_tick(u, d, l, r, $urandom_range(0, 4) == 0, lk);
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
